// File: rtl/pixel_stream_tx_if.sv
// Pixel stream bus: upstream pixel handshake into the transmitter and the
// registered video stream out of it.
interface pixel_stream_tx_if;
  logic [7:0] InData;
  logic       InValid;
  logic       InReady;
  logic [7:0] PixelOut;
  logic       FrameOut;
  logic       LineOut;

  modport slave (
    input  InData, InValid,
    output InReady, PixelOut, FrameOut, LineOut
  );

  modport master (
    output InData, InValid,
    input  InReady, PixelOut, FrameOut, LineOut
  );
endinterface

// File: rtl/pixel_stream_tx.sv
// Frame transmitter: buffers upstream pixels in a FIFO and streams Width x Height
// frames with HBLANK blank cycles after each line. Optional test pattern: PIXEL_STREAM_TX_TEST_PATTERN_EN.
module pixel_stream_tx #(
  parameter int DEPTH  = 16,
  parameter int HBLANK = 4
) (
  input  logic              Clk,
  input  logic              nReset,
  pixel_stream_tx_if.slave  bus,
  input  logic              Start,
  input  logic [7:0]        Width,
  input  logic [7:0]        Height,
  input  logic              TestMode,
  output logic              Busy,
  output logic              FrameDone,
  output logic              Underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = (HBLANK > 1) ? $clog2(HBLANK) : 1;

  typedef enum logic [1:0] {IDLE, LINE, BLANK} state_e;

  // FIFO
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          fifo_full, fifo_empty, push, pop;

  assign fifo_full   = (cnt_q == (AW+1)'(DEPTH));
  assign fifo_empty  = (cnt_q == '0);
  assign bus.InReady = ~fifo_full;
  assign push        = bus.InValid & ~fifo_full;

  // NOTE: storage is deliberately not reset; the pointers and count define validity.
  always_ff @(posedge Clk) begin
    if (push) mem[wr_q] <= bus.InData;
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Frame sequencer; a pixel is registered on the same edge that selects its column.
  state_e        state_q, state_d;
  logic [7:0]    col_q, col_d, row_q, row_d;
  logic [7:0]    width_q, width_d, height_q, height_d;
  logic [BW-1:0] blank_q, blank_d;
  logic [7:0]    pix_q, pix_d;
  logic          frame_q, frame_d, line_q, line_d;
  logic          done_q, done_d, underrun_q, underrun_d;
  logic          emit, pat_mode;

`ifdef PIXEL_STREAM_TX_TEST_PATTERN_EN
  logic tm_q, tm_d;
`else
  logic unused_test_mode;
  assign unused_test_mode = TestMode;
`endif

  // NOTE: every signal gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    blank_d    = blank_q;
    width_d    = width_q;
    height_d   = height_q;
`ifdef PIXEL_STREAM_TX_TEST_PATTERN_EN
    tm_d       = tm_q;
`endif
    emit       = 1'b0;
    pop        = 1'b0;
    pix_d      = '0;
    frame_d    = 1'b0;
    line_d     = 1'b0;
    done_d     = 1'b0;
    underrun_d = underrun_q;

    case (state_q)
      IDLE: begin
        if (Start && (Width != '0) && (Height != '0)) begin
          width_d    = Width;
          height_d   = Height;
`ifdef PIXEL_STREAM_TX_TEST_PATTERN_EN
          tm_d       = TestMode;
`endif
          underrun_d = 1'b0;
          state_d    = LINE;
          col_d      = '0;
          row_d      = '0;
          emit       = 1'b1;
        end
      end
      LINE: begin
        if (col_q == width_q - 8'd1) begin
          state_d = BLANK;
          blank_d = '0;
        end else begin
          col_d = col_q + 8'd1;
          emit  = 1'b1;
        end
      end
      BLANK: begin
        if (blank_q == BW'(HBLANK - 1)) begin
          col_d = '0;
          if (row_q == height_q - 8'd1) begin
            state_d = IDLE;
            row_d   = '0;
            done_d  = 1'b1;
          end else begin
            state_d = LINE;
            row_d   = row_q + 8'd1;
            emit    = 1'b1;
          end
        end else begin
          blank_d = blank_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef PIXEL_STREAM_TX_TEST_PATTERN_EN
    pat_mode = tm_d;
`else
    pat_mode = 1'b0;
`endif

    if (emit) begin
      line_d  = (col_d == '0);
      frame_d = (col_d == '0) && (row_d == '0);
      if (pat_mode) begin
        pix_d = col_d + row_d;
      end else if (fifo_empty) begin
        underrun_d = 1'b1;
      end else begin
        pix_d = mem[rd_q];
        pop   = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      blank_q    <= '0;
      width_q    <= '0;
      height_q   <= '0;
      pix_q      <= '0;
      frame_q    <= 1'b0;
      line_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
`ifdef PIXEL_STREAM_TX_TEST_PATTERN_EN
      tm_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      blank_q    <= blank_d;
      width_q    <= width_d;
      height_q   <= height_d;
      pix_q      <= pix_d;
      frame_q    <= frame_d;
      line_q     <= line_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
`ifdef PIXEL_STREAM_TX_TEST_PATTERN_EN
      tm_q       <= tm_d;
`endif
    end
  end

  assign bus.PixelOut = pix_q;
  assign bus.FrameOut = frame_q;
  assign bus.LineOut  = line_q;
  assign Busy         = (state_q != IDLE);
  assign FrameDone    = done_q;
  assign Underrun     = underrun_q;

endmodule
